// File: rtl/uart_loader.sv
// uart_loader: boot-time loader draining the UART RX FIFO into instruction memory.
// Optional byte echo through the UART TX port when UART_LOADER_ECHO_EN is defined.
module uart_loader #(
    parameter int unsigned       ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 2**14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              uart_empty,
    output logic              uart_rdreq,
    input  logic [7:0]        uart_rdata,
    input  logic              uart_tx_full,
    output logic              uart_wrreq,
    output logic [7:0]        uart_wdata,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              core_rst_n
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_DONE, S_ERR} state_t;
    typedef enum logic [1:0] {P_FETCH, P_CAPT, P_WR, P_PEND} phase_t;

    state_t            r_state;
    phase_t            r_ph;
    logic [1:0]        r_idx;
    logic [31:0]       r_shift;
    logic [31:0]       r_n;
    logic [31:0]       r_cnt;
    logic              r_rdreq;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       w_word;
    logic              w_hold;

`ifdef UART_LOADER_ECHO_EN
    logic       r_wrreq;
    logic [7:0] r_tx;
    assign w_hold     = uart_tx_full;
    assign uart_wrreq = r_wrreq;
    assign uart_wdata = r_tx;
`else
    logic w_unused_tx_full;
    assign w_unused_tx_full = uart_tx_full;
    assign w_hold     = 1'b0;
    assign uart_wrreq = 1'b0;
    assign uart_wdata = '0;
`endif

    // In CAPT the new byte is merged on the fly; in PEND it already sits in r_shift.
    always_comb begin
        w_word = r_shift;
        if (r_ph == P_CAPT)
            w_word[{r_idx, 3'b000} +: 8] = uart_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ph    <= P_FETCH;
            r_idx   <= '0;
            r_shift <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_rdreq <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_wdata <= '0;
`ifdef UART_LOADER_ECHO_EN
            r_wrreq <= 1'b0;
            r_tx    <= '0;
`endif
        end else begin
            r_rdreq <= 1'b0;
            r_we    <= 1'b0;
`ifdef UART_LOADER_ECHO_EN
            r_wrreq <= 1'b0;
`endif
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state <= S_HDR;
                        r_ph    <= P_FETCH;
                        r_idx   <= '0;
                        r_shift <= '0;
                        r_n     <= '0;
                        r_cnt   <= '0;
                        r_rdreq <= !uart_empty;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                default: begin
                    case (r_ph)
                        P_FETCH: begin
                            if (r_rdreq)
                                r_ph <= P_CAPT;
                            else
                                r_rdreq <= !uart_empty;
                        end
                        P_WR: begin
                            if (r_cnt == r_n) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_addr  <= r_addr + 1'b1;
                                r_ph    <= P_FETCH;
                                r_rdreq <= !uart_empty;
                            end
                        end
                        default: begin
                            r_shift <= w_word;
                            if (w_hold) begin
                                r_ph <= P_PEND;
                            end else begin
`ifdef UART_LOADER_ECHO_EN
                                r_wrreq <= 1'b1;
                                r_tx    <= w_word[{r_idx, 3'b000} +: 8];
`endif
                                r_idx <= r_idx + 1'b1;
                                r_ph  <= P_FETCH;
                                if (r_idx != 2'd3) begin
                                    r_rdreq <= !uart_empty;
                                end else if (r_state == S_HDR) begin
                                    r_n <= w_word;
                                    if (w_word == '0) begin
                                        r_state <= S_DONE;
                                        r_busy  <= 1'b0;
                                        r_done  <= 1'b1;
                                    end else if (w_word > 32'(MAX_WORDS)) begin
                                        r_state <= S_ERR;
                                        r_busy  <= 1'b0;
                                        r_error <= 1'b1;
                                    end else begin
                                        r_state <= S_BODY;
                                        r_addr  <= BASE_ADDR;
                                        r_rdreq <= !uart_empty;
                                    end
                                end else begin
                                    r_we    <= 1'b1;
                                    r_wdata <= w_word;
                                    r_cnt   <= r_cnt + 32'd1;
                                    r_ph    <= P_WR;
                                end
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign uart_rdreq = r_rdreq;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign core_rst_n = r_done;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: scoreboard bench for uart_loader with a queue-based RX FIFO model.
// Echo checks are compiled in when UART_LOADER_ECHO_EN is defined.
module tb_uart_loader;
    localparam int unsigned   AW   = 14;
    localparam logic [AW-1:0] BASE = 14'h100;
    localparam int unsigned   MAXW = 6;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          start        = 1'b0;
    logic          uart_empty   = 1'b1;
    logic [7:0]    uart_rdata   = 8'h00;
    logic          uart_tx_full = 1'b0;
    logic          uart_rdreq;
    logic          uart_wrreq;
    logic [7:0]    uart_wdata;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, error, core_rst_n;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic [7:0]  rxq[$];
    logic [7:0]  echoq[$];
    logic [7:0]  img[$];
    wr_t         wrq[$];
    wr_t         mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    int unsigned pops  = 0;
    logic [7:0]  ex_img [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56,
                                 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    uart_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .uart_empty(uart_empty), .uart_rdreq(uart_rdreq), .uart_rdata(uart_rdata),
        .uart_tx_full(uart_tx_full), .uart_wrreq(uart_wrreq), .uart_wdata(uart_wdata),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .error(error), .core_rst_n(core_rst_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RX FIFO: a pop seen in one cycle delivers its byte just after the next rising edge
    always begin : rx_fifo
        logic pop;
        @(negedge clk);
        pop = uart_rdreq;
        @(posedge clk);
        #1;
        if (pop && rxq.size() > 0) begin
            uart_rdata = rxq.pop_front();
            pops++;
        end
        uart_empty = (rxq.size() == 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (uart_rdreq) chk("rdreq_while_empty", uart_empty, 0);
            if (imem_we) begin
                if (wrq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
                end else begin
                    mon_e = wrq.pop_front();
                    chk("imem_addr", imem_addr, mon_e.a);
                    chk("imem_wdata", imem_wdata, mon_e.d);
                end
            end
            if (uart_wrreq) begin
`ifdef UART_LOADER_ECHO_EN
                chk("wrreq_while_full", uart_tx_full, 0);
                if (echoq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_echo: byte 0x%0h, expected no echo", uart_wdata);
                end else begin
                    chk("echo_byte", uart_wdata, echoq.pop_front());
                end
`else
                n_cmp++; n_bad++;
                $display("FAIL wrreq_tied: got 1, expected 0");
`endif
            end
        end
    end

    // Reference model: little-endian count, then N little-endian words at BASE+i mod 2**AW
    task automatic expect_from_img(output bit exp_done, output bit exp_err, output int unsigned n);
        logic [31:0] d;
        wr_t         e;
        n = 0;
        for (int unsigned i = 0; i < 4; i++) n = n + (32'(img[i]) << (8 * i));
        exp_err  = (n > MAXW);
        exp_done = !exp_err;
        wrq.delete();
        echoq = img;
        if (!exp_err) begin
            for (int unsigned w = 0; w < n; w++) begin
                d = 0;
                for (int unsigned b = 0; b < 4; b++) d = d + (32'(img[4 + 4 * w + b]) << (8 * b));
                e.a = AW'((32'(BASE) + w) % (32'd1 << AW));
                e.d = d;
                wrq.push_back(e);
            end
        end
    endtask

    task automatic make_img(input int unsigned n);
        img.delete();
        for (int unsigned i = 0; i < 4; i++) img.push_back(8'(n >> (8 * i)));
        if (n <= MAXW)
            for (int unsigned i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    task automatic load_example();
        img.delete();
        foreach (ex_img[i]) img.push_back(ex_img[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdreq"}, uart_rdreq, 0);
        chk({tag, "_wrreq"}, uart_wrreq, 0);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_core_rst_n"}, core_rst_n, 0);
        chk({tag, "_addr"}, imem_addr, BASE);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_uart_wdata"}, uart_wdata, 0);
    endtask

    task automatic pulse_start(output int unsigned s_edge);
        start  = 1'b1;
        s_edge = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_load(input bit preload, input int unsigned gap, input bit chk_lat);
        bit          ed, ee, seen;
        int unsigned n, s_edge;
        expect_from_img(ed, ee, n);
        if (preload) begin
            foreach (img[i]) rxq.push_back(img[i]);
            repeat (3) @(posedge clk);
        end else begin
            @(posedge clk);
        end
        #1;
        pulse_start(s_edge);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        chk("error_after_start", error, 0);
        if (!preload) begin
            foreach (img[i]) begin
                rxq.push_back(img[i]);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        seen = 0;
        for (int unsigned k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done || error) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL load_timeout: no done/error in 3000 cycles, expected done=%0d error=%0d", ed, ee);
        end else if (chk_lat) begin
            chk("done_latency", cyc - s_edge, ee ? 8 : 8 + 9 * n);
        end
        chk("done", done, ed);
        chk("error", error, ee);
        chk("core_rst_n", core_rst_n, ed);
        chk("busy_end", busy, 0);
        @(negedge clk);
        chk("writes_left", wrq.size(), 0);
`ifdef UART_LOADER_ECHO_EN
        chk("echo_left", echoq.size(), 0);
`endif
    endtask

    initial begin : main
        bit          ed, ee, hit;
        int unsigned n, s_edge;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        load_example();
        run_load(1, 0, 1);

        make_img(0);
        run_load(1, 0, 1);

        make_img(MAXW + 1);
        run_load(1, 0, 1);
        repeat (5) @(negedge clk);
        chk("error_sticky", error, 1);
        load_example();
        run_load(1, 0, 1);

        make_img(MAXW);
        run_load(1, 0, 1);

        load_example();
        run_load(0, 50, 0);

        load_example();
        expect_from_img(ed, ee, n);
        foreach (img[i]) rxq.push_back(img[i]);
        repeat (3) @(posedge clk);
        #1;
        pulse_start(s_edge);
        hit = 0;
        for (int unsigned k = 0; k < 200; k++) begin
            @(negedge clk);
            if (wrq.size() == 1) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            n_cmp++; n_bad++;
            $display("FAIL first_write_timeout: %0d writes pending, expected 1", wrq.size());
        end
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        rxq.delete();
        wrq.delete();
        echoq.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        load_example();
        run_load(1, 0, 1);

`ifdef UART_LOADER_ECHO_EN
        load_example();
        pops = 0;
        fork
            run_load(1, 0, 0);
            begin
                hit = 0;
                for (int unsigned k = 0; k < 500; k++) begin
                    @(posedge clk);
                    #2;
                    if (pops >= 3) begin
                        hit = 1;
                        break;
                    end
                end
                if (hit) begin
                    uart_tx_full = 1'b1;
                    repeat (10) @(posedge clk);
                    #2 uart_tx_full = 1'b0;
                end else begin
                    n_cmp++; n_bad++;
                    $display("FAIL third_pop_timeout: %0d pops, expected 3", pops);
                end
            end
        join
`endif

        for (int unsigned r = 0; r < 10; r++) begin
            int unsigned nw;
            bit          pre;
            nw = $urandom_range(0, MAXW);
            if ($urandom_range(0, 4) == 0) nw = MAXW + 1 + $urandom_range(0, 100000);
            make_img(nw);
            pre = 1'($urandom_range(0, 1));
            run_load(pre, pre ? 0 : $urandom_range(1, 4), pre);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, expected summary before it");
        $fatal(1, "watchdog");
    end

endmodule
